// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the 4-digit 7-segment scan
//               controller (blank patterns, phase state enum, digit index).
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // All anodes off (active-low)
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Scan phase: blank dead-time or digit lit
  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  // Digit index 3 (leftmost) .. 0 (rightmost)
  typedef logic [1:0] digit_idx_t;

  // Larger of two integers, used for the phase counter width
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_leddecoder.sv
`default_nettype none
// ============================================================================
// Module      : LEDdecoder
// Description : Hex nibble to active-low 7-segment pattern, bit 6 = a ..
//               bit 0 = g. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module LEDdecoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Glyph lookup; lowercase b and d keep them distinct from 8 and 0
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit common-anode
//               7-segment display. One shared decoder, one active-low anode
//               at a time, frame-synchronous snapshot of the display value.
//               Define SEG7_DEADTIME_EN to insert DEAD_CYCLES blank cycles
//               before every digit's on-phase (anti-ghosting).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DEAD_CYCLES = 16,
  parameter int ON_CYCLES   = 12500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int CW_RAW = $clog2(max_int(DEAD_CYCLES, ON_CYCLES));
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
`ifdef SEG7_DEADTIME_EN
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam state_t        ST_RESET  = ST_DEAD;
`else
  localparam state_t        ST_RESET  = ST_ON;
`endif

  // State/idx/cnt describe the cycle whose outputs appear at the next edge
  state_t        state, state_nxt;
  digit_idx_t    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          frame_wrap;
  logic [15:0]   snap_d;
  logic [3:0]    snap_en;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          lit;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          tick_nxt;

  assign nibble = snap_d[{idx, 2'b00} +: 4];

  LEDdecoder u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Phase sequencing: count within a phase, switch phase / digit on the last count
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt + 1'b1;
    frame_wrap = 1'b0;
`ifdef SEG7_DEADTIME_EN
    if (state == ST_DEAD) begin
      if (cnt == DEAD_LAST) begin
        state_nxt = ST_ON;
        cnt_nxt   = '0;
      end
    end else begin
      if (cnt == ON_LAST) begin
        state_nxt  = ST_DEAD;
        cnt_nxt    = '0;
        idx_nxt    = idx - 1'b1;
        frame_wrap = (idx == 2'd0);
      end
    end
`else
    if (cnt == ON_LAST) begin
      cnt_nxt    = '0;
      idx_nxt    = idx - 1'b1;
      frame_wrap = (idx == 2'd0);
    end
`endif
  end

  // Output pattern for the current phase; disabled digits stay fully blank
  always_comb begin
    lit      = (state == ST_ON) && snap_en[idx];
    an_nxt   = lit ? ~(4'b0001 << idx) : AN_OFF;
    seg_nxt  = lit ? dec_seg : SEG_BLANK;
    tick_nxt = (state == ST_ON) && (idx == 2'd0) && (cnt == ON_LAST);
  end

  // Scan state and registered pin outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RESET;
      idx        <= 2'd3;
      cnt        <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= tick_nxt;
    end
  end

  // Frame snapshot: inputs are only sampled at frame start so a frame never tears
  always_ff @(posedge clk) begin
    if (reset || frame_wrap) begin
      snap_d  <= digits;
      snap_en <= digit_en;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It shares one hex-to-segment decoder across all four digits and drives one active-low anode at a time. Optional blanking dead-time separates digits to suppress ghosting. It sits between the display-value logic (counters, message scrollers) and the board's anode/segment pins.

## Interface

- `DEAD_CYCLES`, default 16: blank cycles before each digit's on-phase (≥1; ignored without dead-time).
- `ON_CYCLES`, default 12500: cycles each digit is lit (≥1).
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `digits`  in  16: four hex nibbles; [15:12] → digit 3 (leftmost, `an[3]`) … [3:0] → digit 0.
- `digit_en`  in  4: per-digit enable; 0 keeps that anode off for its whole slot.
- `an`  out  4: anode selects, active-low, one-hot-low or all 1s.
- `seg`  out  7: segments, active-low, bit 6 = a … bit 0 = g.
- `frame_tick`  out  1: one-cycle pulse on the last on-cycle of digit 0.

## Operation

- FSM states: DEAD (anodes off), ON (selected anode low). Digit index `idx` scans 3→2→1→0→3.
- Phase counter `cnt` counts 0..N-1 within each phase, where N = DEAD_CYCLES or ON_CYCLES. The FSM changes phase when `cnt` = N-1, and `cnt` returns to 0.
- DEAD→ON on the same digit. ON→DEAD and advance `idx`.
- `idx` wrapping 0→3 marks a frame start. On that edge, snapshot registers `snap_d` ← `digits` and `snap_en` ← `digit_en`. Mid-frame changes to the inputs are invisible until the next frame.
- The decoder input is `snap_d` nibble [`idx`]. `seg` and `an` are registered and update on the same edge.
- In ON: `seg` = decode(nibble), `an[idx]` = 0 if `snap_en[idx]`, else `an` = 4'hF and `seg` = 7'h7F.
- In DEAD: `an` = 4'hF, `seg` = 7'h7F.
- Decode table: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- `frame_tick` = 1 exactly on the cycle whose outputs are the final ON cycle of digit 0. It pulses even if digit 0 is disabled.

## Timing

- Reset values: `an` = 4'hF, `seg` = 7'h7F, `frame_tick` = 0, state = DEAD (ON without dead-time), `idx` = 3, `cnt` = 0.
- While `reset` is high, `snap_d`/`snap_en` load `digits`/`digit_en` every cycle.
- After reset falls: DEAD_CYCLES blank cycles, then digit 3 lit for ON_CYCLES, and so on.
- Frame period = 4·(DEAD_CYCLES+ON_CYCLES) cycles (4·ON_CYCLES without dead-time). There are no gaps and no drift.
- Reset asserted mid-phase: outputs are blank on the next edge and the scan restarts at digit 3 DEAD.
- At most one anode is low in any cycle.
- `seg` never changes while an anode is low except at an ON→ON digit boundary, which occurs only without dead-time.

## Configuration

- `SEG7_DEADTIME_EN` defined: the DEAD state exists as described.
- `SEG7_DEADTIME_EN` undefined: the DEAD state is removed and `DEAD_CYCLES` is unused. The FSM is ON-only, `idx` advances every ON_CYCLES, and `an`/`seg` switch together on the boundary edge. Reset values are unchanged, and the first lit cycle is the first edge after reset release.

## Structure

- Shared package `seg7_pkg`: `SEG_BLANK` = 7'h7F, `AN_OFF` = 4'hF, state enum {ST_DEAD, ST_ON}, and the 2-bit digit-index type.
- Counter width = $clog2(max(DEAD_CYCLES, ON_CYCLES)).
- One sub-module: the existing `LEDdecoder`, instantiated once and fed by the `idx` mux.

## Test plan

- With DEAD=2, ON=3, `digits` = 16'h1234, `digit_en` = 4'hF, release reset: 2 cycles `an` = F; 3 cycles `an` = 0111/`seg` = 1001111; 2 blank; 3 cycles `an` = 1011/`seg` = 0010010; and so on through digit 0 (`seg` = 1001100). `frame_tick` goes high on cycle 20.
- Change `digits` to 16'hABCD mid-frame: the current frame still shows 1234, and the next frame shows A, b, C, d (0001000, 1100000, 0110001, 1000010).
- `digit_en` = 4'b1010: only `an` = 0111 and `an` = 1101 ever go low. `frame_tick` still has a 20-cycle period.
- Assert reset for 1 cycle during digit 1 ON: next edge `an` = F, `seg` = 7F. The scan resumes at digit 3 after 2 blank cycles.
- Without `SEG7_DEADTIME_EN`, ON=3: `an` sequence 0111×3, 1011×3, 1101×3, 1110×3 with no blank cycles. `frame_tick` period is 12.
- Assertion over a long random run: `an` is never two-low, and the frame period is constant.
